// File: rtl/complex_mult_pkg.sv
// rtl/complex_mult_pkg.sv - shared widths, complex operand types and output saturation helper
package complex_mult_pkg;

  localparam int IN_W  = 8;
  localparam int OUT_W = 2 * IN_W;

  typedef struct packed {
    logic signed [IN_W-1:0] re;
    logic signed [IN_W-1:0] im;
  } cplx_in_t;

  typedef struct packed {
    logic signed [OUT_W-1:0] re;
    logic signed [OUT_W-1:0] im;
  } cplx_out_t;

  // Clamp an OUT_W+1 bit value to the OUT_W signed range; only the top two bits decide.
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [OUT_W:0] x);
    if (x[OUT_W] != x[OUT_W-1]) begin
      sat_out = x[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      sat_out = x[OUT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/signed_mult.sv
// rtl/signed_mult.sv - registered signed IN_W x IN_W multiplier with load enable
module signed_mult
  import complex_mult_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_en,
  input  logic signed [IN_W-1:0] i_a,
  input  logic signed [IN_W-1:0] i_b,
  output logic signed [2*IN_W-1:0] o_p
);

  logic signed [2*IN_W-1:0] r_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p <= '0;
    end else if (i_en) begin
      r_p <= i_a * i_b;
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/complex_mult.sv
// rtl/complex_mult.sv - two-stage pipelined signed complex multiplier; COMPLEX_MULT_SATURATE_EN selects saturation over wrap
module complex_mult
  import complex_mult_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  a_real,
  input  logic signed [IN_W-1:0]  a_imag,
  input  logic signed [IN_W-1:0]  b_real,
  input  logic signed [IN_W-1:0]  b_imag,
  input  logic [1:0]              data_valid,
  output logic signed [OUT_W-1:0] z_real,
  output logic signed [OUT_W-1:0] z_imag,
  output logic                    z_valid
);

  cplx_in_t  w_a;
  cplx_in_t  w_b;
  cplx_out_t w_z_next;
  cplx_out_t r_z;
  logic      r_v1;
  logic      r_zv;
  logic      w_en;

  logic signed [OUT_W-1:0] w_p_rr;
  logic signed [OUT_W-1:0] w_p_ii;
  logic signed [OUT_W-1:0] w_p_ri;
  logic signed [OUT_W-1:0] w_p_ir;
  logic signed [OUT_W:0]   w_re_full;
  logic signed [OUT_W:0]   w_im_full;

  assign w_a  = '{re: a_real, im: a_imag};
  assign w_b  = '{re: b_real, im: b_imag};
  assign w_en = data_valid[0];

  signed_mult u_mult_rr (.clk(clk), .rst(rst), .i_en(w_en), .i_a(w_a.re), .i_b(w_b.re), .o_p(w_p_rr));
  signed_mult u_mult_ii (.clk(clk), .rst(rst), .i_en(w_en), .i_a(w_a.im), .i_b(w_b.im), .o_p(w_p_ii));
  signed_mult u_mult_ri (.clk(clk), .rst(rst), .i_en(w_en), .i_a(w_a.re), .i_b(w_b.im), .o_p(w_p_ri));
  signed_mult u_mult_ir (.clk(clk), .rst(rst), .i_en(w_en), .i_a(w_a.im), .i_b(w_b.re), .o_p(w_p_ir));

  // One guard bit: only the imaginary sum of four -128 operands reaches it.
  assign w_re_full = (OUT_W+1)'(w_p_rr) - (OUT_W+1)'(w_p_ii);
  assign w_im_full = (OUT_W+1)'(w_p_ri) + (OUT_W+1)'(w_p_ir);

`ifdef COMPLEX_MULT_SATURATE_EN
  logic w_unused;
  assign w_unused    = data_valid[1];
  assign w_z_next.re = sat_out(w_re_full);
  assign w_z_next.im = sat_out(w_im_full);
`else
  logic [2:0] w_unused;
  assign w_unused    = {data_valid[1], w_re_full[OUT_W], w_im_full[OUT_W]};
  assign w_z_next.re = w_re_full[OUT_W-1:0];
  assign w_z_next.im = w_im_full[OUT_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_zv <= 1'b0;
      r_z  <= '0;
    end else begin
      r_v1 <= w_en;
      r_zv <= r_v1;
      if (r_v1) begin
        r_z <= w_z_next;
      end
    end
  end

  assign z_real  = r_z.re;
  assign z_imag  = r_z.im;
  assign z_valid = r_zv;

endmodule

// File: tb/tb_complex_mult.sv
// tb/tb_complex_mult.sv - directed self-checking bench for complex_mult
module tb_complex_mult;

  logic               clk;
  logic               rst;
  logic signed [7:0]  a_real;
  logic signed [7:0]  a_imag;
  logic signed [7:0]  b_real;
  logic signed [7:0]  b_imag;
  logic [1:0]         data_valid;
  logic signed [15:0] z_real;
  logic signed [15:0] z_imag;
  logic               z_valid;

  int checks = 0;
  int errors = 0;

  complex_mult dut (
    .clk(clk), .rst(rst),
    .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
    .data_valid(data_valid),
    .z_real(z_real), .z_imag(z_imag), .z_valid(z_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ar, input int ai, input int br, input int bi, input logic [1:0] dv);
    a_real     = 8'(ar);
    a_imag     = 8'(ai);
    b_real     = 8'(br);
    b_imag     = 8'(bi);
    data_valid = dv;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
  endtask

  task automatic check_out(input string tag, input int exp_re, input int exp_im, input logic exp_v);
    check({tag, ".real"},  z_real, 16'(exp_re));
    check({tag, ".imag"},  z_imag, 16'(exp_im));
    check({tag, ".valid"}, {15'd0, z_valid}, {15'd0, exp_v});
  endtask

  int exp_ovf_im;

  initial begin
`ifdef COMPLEX_MULT_SATURATE_EN
    exp_ovf_im = 32767;
`else
    exp_ovf_im = -32768;
`endif
    rst = 1'b1;
    drive(50, 25, 15, 30, 2'b01);
    tick();
    tick();
    check_out("reset_hold", 0, 0, 1'b0);
    rst = 1'b0;

    drive(50, 25, 15, 30, 2'b01);
    tick();
    drive(1, 2, 3, 4, 2'b01);
    tick();
    check_out("vec_a", 0, 1875, 1'b1);
    drive(9, 9, 9, 9, 2'b00);
    tick();
    check_out("vec_b_b2b", -5, 10, 1'b1);
    drive(5, 5, 5, 5, 2'b10);
    tick();
    check_out("dv00_hold", -5, 10, 1'b0);
    drive(7, 7, 7, 7, 2'b00);
    tick();
    check_out("dv10_hold", -5, 10, 1'b0);

    drive(-128, -128, -128, -128, 2'b01);
    tick();
    drive(-128, 0, -128, 0, 2'b01);
    tick();
    check_out("overflow", 0, exp_ovf_im, 1'b1);
    drive(127, 127, 127, -127, 2'b01);
    tick();
    check_out("neg_real_sq", 16384, 0, 1'b1);
    drive(0, 0, 0, 0, 2'b00);
    tick();
    check_out("max_conj", 32258, 0, 1'b1);

    drive(10, 0, 10, 0, 2'b01);
    tick();
    check_out("pre_reset", 32258, 0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_out("async_reset", 0, 0, 1'b0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 2'b00);
    tick();
    check_out("post_reset_1", 0, 0, 1'b0);
    tick();
    check_out("post_reset_2", 0, 0, 1'b0);

    drive(3, 0, 4, 0, 2'b01);
    tick();
    check_out("after_rst_lat1", 0, 0, 1'b0);
    drive(0, 0, 0, 0, 2'b00);
    tick();
    check_out("after_rst_lat2", 12, 0, 1'b1);
    tick();
    check_out("after_rst_drop", 12, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
